two_to_one_mux: RTL and testbench

Single-bit-slice 2:1 data selector with a combinational output and an optional registered copy. Y follows D0 when S=0 and D1 when S=1 with no clock involvement. A clocked, asynchronously reset output register provides a one-cycle-latency version, Y_q, for timing-closed consumers. The block is a leaf datapath primitive, instantiated wherever a select between two sources is needed.

---
 rtl/two_to_one_mux_if.sv | 27 ++
 rtl/two_to_one_mux.sv | 35 +++
 tb/tb_two_to_one_mux.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/two_to_one_mux_if.sv
// two_to_one_mux_if: data/select bundle for the 2:1 selector.
// Carries both inputs, the select line and both output copies.
interface two_to_one_mux_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic             S;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_q;

  modport master (
    output D0,
    output D1,
    output S,
    input  Y,
    input  Y_q
  );

  modport slave (
    input  D0,
    input  D1,
    input  S,
    output Y,
    output Y_q
  );
endinterface

// File: rtl/two_to_one_mux.sv
// two_to_one_mux: bitwise 2:1 selector with combinational Y
// and an optional async-reset registered copy Y_q.
module two_to_one_mux #(
  parameter int WIDTH  = 1,
  parameter bit REG_EN = 1'b1
) (
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             S,
  output logic [WIDTH-1:0] Y,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Y_q
);

  // Ternary keeps X on bits where D0/D1 differ when S is unknown
  assign Y = S ? D1 : D0;

  generate
    if (REG_EN) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          Y_q <= '0;
        end else begin
          Y_q <= Y;
        end
      end
    end else begin : g_noreg
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign Y_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_two_to_one_mux.sv
// tb_two_to_one_mux: directed and randomized checks of the
// combinational and registered selector outputs.
module tb_two_to_one_mux;

  logic clk;
  logic rst;
  logic clk_run;
  int   tests;
  int   fails;

  logic [7:0] exp_q1;
  logic [7:0] exp_q8;
  logic [7:0] tt;

  two_to_one_mux_if #(.WIDTH(1)) bus1 ();
  two_to_one_mux_if #(.WIDTH(8)) bus8 ();

  logic y_pos;
  logic yq_pos;

  two_to_one_mux #(.WIDTH(1)) u1 (
    .D0  (bus1.D0),
    .D1  (bus1.D1),
    .S   (bus1.S),
    .Y   (bus1.Y),
    .clk (clk),
    .rst (rst),
    .Y_q (bus1.Y_q)
  );

  two_to_one_mux #(.WIDTH(8)) u8 (
    .D0  (bus8.D0),
    .D1  (bus8.D1),
    .S   (bus8.S),
    .Y   (bus8.Y),
    .clk (clk),
    .rst (rst),
    .Y_q (bus8.Y_q)
  );

  // Positional order D0, D1, S, Y, clk, rst, Y_q
  two_to_one_mux u_pos (
    bus1.D0, bus1.D1, bus1.S, y_pos, 1'b0, 1'b0, yq_pos
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Reference: per-bit lookup in the truth table (index {S,D0,D1})
  function automatic logic [7:0] ref_mux(
    input logic       s,
    input logic [7:0] d0,
    input logic [7:0] d1
  );
    logic [7:0] r;
    logic [7:0] tab;
    tab = 8'b1010_1100;
    r = '0;
    for (int b = 0; b < 8; b++) r[b] = tab[{s, d0[b], d1[b]}];
    return r;
  endfunction

  task automatic check(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic r;
    logic [7:0] e;
    tests   = 0;
    fails   = 0;
    clk_run = 1'b0;
    tt      = 8'b1010_1100;
    rst     = 1'b1;
    bus1.D0 = 1'b0;
    bus1.D1 = 1'b0;
    bus1.S  = 1'b0;
    bus8.D0 = 8'h00;
    bus8.D1 = 8'h00;
    bus8.S  = 1'b0;
    #1;
    check("reset_yq1", {7'b0, bus1.Y_q}, 8'h00);
    check("reset_yq8", bus8.Y_q, 8'h00);

    $display("S | D0 | D1 || Y");
    for (int i = 0; i < 8; i++) begin
      {bus1.S, bus1.D0, bus1.D1} = 3'(i);
      #20;
      $display("%b | %b  | %b  || %b",
               bus1.S, bus1.D0, bus1.D1, bus1.Y);
      e = {7'b0, tt[i]};
      check("sweep_y", {7'b0, bus1.Y}, e);
      check("sweep_pos", {7'b0, y_pos}, e);
    end

    bus1.D0 = 1'b1;
    bus1.D1 = 1'b0;
    bus1.S  = 1'b0;
    #1 check("tog_s0", {7'b0, bus1.Y}, 8'h01);
    bus1.S = 1'b1;
    #1 check("tog_s1", {7'b0, bus1.Y}, 8'h00);
    bus1.S = 1'b0;
    #1 check("tog_s0b", {7'b0, bus1.Y}, 8'h01);

    bus1.S  = 1'b1;
    bus1.D1 = 1'b1;
    bus1.D0 = 1'b0;
    clk_run = 1'b1;
    @(posedge clk);
    #1 check("rst_hold", {7'b0, bus1.Y_q}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_pre", {7'b0, bus1.Y_q}, 8'h00);
    @(posedge clk);
    #1 check("rel_cap", {7'b0, bus1.Y_q}, 8'h01);

    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_yq", {7'b0, bus1.Y_q}, 8'h00);
    check("async_y", {7'b0, bus1.Y}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("recap", {7'b0, bus1.Y_q}, 8'h01);
    @(posedge clk);
    rst = 1'b1;
    #1 check("edge_rst", {7'b0, bus1.Y_q}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    bus8.D0 = 8'hA5;
    bus8.D1 = 8'h3C;
    bus8.S  = 1'b0;
    #1 check("w8_s0", bus8.Y, 8'hA5);
    @(posedge clk);
    #1 check("w8_q0", bus8.Y_q, 8'hA5);
    bus8.S = 1'b1;
    #1;
    check("w8_s1", bus8.Y, 8'h3C);
    check("w8_hold", bus8.Y_q, 8'hA5);
    @(posedge clk);
    #1 check("w8_q1", bus8.Y_q, 8'h3C);

    exp_q1 = {7'b0, bus1.Y_q === 1'b1};
    exp_q8 = 8'h3C;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus1.D0 = 1'($urandom);
      bus1.D1 = 1'($urandom);
      bus1.S  = 1'($urandom);
      bus8.D0 = 8'($urandom);
      bus8.D1 = 8'($urandom);
      bus8.S  = 1'($urandom);
      r = ($urandom_range(0, 7) == 0);
      rst = r;
      if (r) begin
        exp_q1 = 8'h00;
        exp_q8 = 8'h00;
      end
      #1;
      e = ref_mux(bus1.S, {7'b0, bus1.D0}, {7'b0, bus1.D1});
      check("rnd_y1", {7'b0, bus1.Y}, e);
      check("rnd_pos", {7'b0, y_pos}, e);
      check("rnd_y8", bus8.Y, ref_mux(bus8.S, bus8.D0, bus8.D1));
      check("rnd_q1_pre", {7'b0, bus1.Y_q}, exp_q1);
      check("rnd_q8_pre", bus8.Y_q, exp_q8);
      @(posedge clk);
      if (!r) begin
        exp_q1 = e;
        exp_q8 = ref_mux(bus8.S, bus8.D0, bus8.D1);
      end
      #1;
      check("rnd_q1", {7'b0, bus1.Y_q}, exp_q1);
      check("rnd_q8", bus8.Y_q, exp_q8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
